// File: rtl/io_out_fifo.sv
// Output FIFO between the core's IO write strobe and a valid/ready consumer.
// First-word-fall-through, never stalls the core; dropped words raise a sticky ovf flag.
module io_out_fifo #(
    parameter  int NBMANT = 16,
    parameter  int NBEXPO = 6,
    parameter  int NUIOOU = 8,
    parameter  int FDEPTH = 8,
    localparam int W      = NBMANT + NBEXPO + 1,
    localparam int A      = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
    localparam int PW     = $clog2(FDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          out_en,
    input  logic [A-1:0]  addr_out,
    input  logic [W-1:0]  data_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic [A-1:0]  m_addr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    input  logic          ovf_clr
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem_data [FDEPTH];
    logic          push;
    logic          pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FDEPTH));
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push    = out_en && (!full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Overflow has priority over a same-cycle clear.
            if (out_en && full && !pop) ovf <= 1'b1;
            else if (ovf_clr)           ovf <= 1'b0;
        end
    end

    // NOTE: storage is deliberately left out of reset; the head is only
    // meaningful while m_valid is high, so clearing it would add reset fanout for nothing.
    always_ff @(posedge clk) begin
        if (push) mem_data[wr_ptr] <= data_out;
    end

    assign m_data = mem_data[rd_ptr];

    generate
        if (NUIOOU > 1) begin : g_tag
            logic [A-1:0] mem_addr [FDEPTH];

            always_ff @(posedge clk) begin
                if (push) mem_addr[wr_ptr] <= addr_out;
            end

            assign m_addr = mem_addr[rd_ptr];
        end else begin : g_no_tag
            assign m_addr = '0;
        end
    endgenerate

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: queue-based reference model feeding a scoreboard,
// directed scenarios followed by random traffic.
module tb_io_out_fifo;

    localparam int NBMANT = 16;
    localparam int NBEXPO = 6;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 8;
    localparam int W  = NBMANT + NBEXPO + 1;
    localparam int A  = $clog2(NUIOOU);
    localparam int CW = $clog2(FDEPTH) + 1;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          out_en = 1'b0;
    logic [A-1:0]  addr_out = '0;
    logic [W-1:0]  data_out = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [A-1:0]  m_addr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    entry_t sb[$];
    int     mcount = 0;
    logic   eovf = 1'b0;

    io_out_fifo #(
        .NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [A-1:0] a, input logic [W-1:0] d);
        out_en   = 1'b1;
        addr_out = a;
        data_out = d;
        tick();
        out_en   = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        mcount = 0;
        eovf   = 1'b0;
    endtask

    // Reference model: a FIFO of words with capacity FDEPTH, updated per accepted edge.
    always @(posedge clk) begin
        if (!rst) begin
            automatic bit mpop  = (mcount > 0) && m_ready;
            automatic bit mpush = out_en && ((mcount < FDEPTH) || mpop);
            if (mpush) sb.push_back('{addr: addr_out, data: data_out});
            mcount = mcount + int'(mpush) - int'(mpop);
            if (out_en && !mpush) eovf = 1'b1;
            else if (ovf_clr)     eovf = 1'b0;
        end
    end

    // Monitor: compares flags against the model and the head against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", m_valid, mcount != 0);
            check("count", count, mcount);
            check("full", full, mcount == FDEPTH);
            check("empty", empty, mcount == 0);
            check("ovf", ovf, eovf);
            if (m_valid && sb.size() != 0) begin
                check("head_data", m_data, sb[0].data);
                check("head_addr", m_addr, sb[0].addr);
                if (m_ready) void'(sb.pop_front());
            end else if (m_valid) begin
                check("head_unexpected", 1'b1, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", m_valid, 0);
        check("rst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single word, 1-cycle latency, then pop
        write(3'd3, W'(32'h12345));
        check("s1_valid", m_valid, 1);
        check("s1_addr", m_addr, 3);
        check("s1_data", m_data, 32'h12345);
        check("s1_count", count, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("s1_empty", empty, 1);
        check("s1_count0", count, 0);

        // Fill to full, then overflow
        for (int i = 0; i < FDEPTH; i++) write(A'(i), W'(100 + i));
        check("s2_full", full, 1);
        check("s2_count", count, FDEPTH);
        write(3'd7, W'(999));
        check("s2_ovf", ovf, 1);
        check("s2_count_ovf", count, FDEPTH);
        check("s2_head", m_data, 100);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("s2_ovf_clr", ovf, 0);

        // Write while full with a simultaneous pop
        m_ready = 1'b1;
        write(3'd2, W'(555));
        m_ready = 1'b0;
        check("s3_ovf", ovf, 0);
        check("s3_count", count, FDEPTH);
        check("s3_head", m_data, 101);

        // Overflow and clear together: overflow wins
        out_en  = 1'b1;
        ovf_clr = 1'b1;
        data_out = W'(777);
        tick();
        out_en  = 1'b0;
        ovf_clr = 1'b0;
        check("s6_ovf_set_wins", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        m_ready = 1'b1;
        for (int i = 0; i < FDEPTH; i++) tick();
        m_ready = 1'b0;
        check("s3_drained", empty, 1);

        // Streaming with continuous ready: pointers wrap, occupancy stays <= 1
        m_ready = 1'b1;
        for (int v = 1; v <= 20; v++) begin
            write(A'(v % NUIOOU), W'(v));
            check("s4_count_le1", count <= 1, 1);
        end
        tick();
        m_ready = 1'b0;
        check("s4_empty", empty, 1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) write(A'(i), W'(200 + i));
        check("s5_count5", count, 5);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("s5_async_count", count, 0);
        check("s5_async_valid", m_valid, 0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        write(3'd5, W'(32'h7777));
        check("s5_after_data", m_data, 32'h7777);
        check("s5_after_addr", m_addr, 5);
        check("s5_after_count", count, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            out_en   = ($urandom_range(0, 99) < 60);
            m_ready  = ($urandom_range(0, 99) < 45);
            ovf_clr  = ($urandom_range(0, 99) < 5);
            addr_out = A'($urandom);
            data_out = W'($urandom);
            tick();
        end
        out_en  = 1'b0;
        ovf_clr = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < FDEPTH + 2; i++) tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("final_empty", empty, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
